// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters (master) and rr_lock_arbiter (slave).
interface rr_lock_arbiter_if #(
    parameter int ARB_WIDTH = 16,
    parameter int IDX_W     = $clog2(ARB_WIDTH)
);
    logic [ARB_WIDTH-1:0] req;
    logic [ARB_WIDTH-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 timeout_pulse;

    modport master (output req, input grant, grant_idx, grant_valid, timeout_pulse);
    modport slave  (input req, output grant, grant_idx, grant_valid, timeout_pulse);
endinterface

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with registered one-hot grant held while the winner keeps requesting.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles of continuous hold.
module rr_lock_arbiter #(
    parameter int ARB_WIDTH = 16,
    parameter int IDX_W     = $clog2(ARB_WIDTH),
    parameter int MAX_HOLD  = 32
) (
    input  logic              clk,
    input  logic              rst,
    rr_lock_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, LOCK} state_t;

    if (ARB_WIDTH < 2 || ARB_WIDTH > 64 || MAX_HOLD < 2) begin : g_param_chk
        $error("rr_lock_arbiter: illegal ARB_WIDTH/MAX_HOLD");
    end

    state_t               state, state_nxt;
    logic [ARB_WIDTH-1:0] grant_q, grant_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic                 valid_q;
    logic [ARB_WIDTH-1:0] cand;
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic                 take;
    logic                 held;

    // First set bit of r scanning p, p+1, ... with wrap at ARB_WIDTH.
    function automatic logic [IDX_W:0] pick(input logic [ARB_WIDTH-1:0] r,
                                            input logic [IDX_W-1:0] p);
        logic           f;
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] jj;
        int             j;
        f = 1'b0;
        w = '0;
        for (int i = 0; i < ARB_WIDTH; i++) begin
            j = int'(p) + i;
            if (j >= ARB_WIDTH) j = j - ARB_WIDTH;
            jj = IDX_W'(j);
            if (!f && r[jj]) begin
                f = 1'b1;
                w = jj;
            end
        end
        return {f, w};
    endfunction

    // The current holder is masked out so a release or timeout never re-picks it.
    assign cand        = (state == LOCK) ? (bus.req & ~grant_q) : bus.req;
    assign {found, win} = pick(cand, ptr);
    assign held        = |(bus.req & grant_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tp_q, tp_nxt;

    always_comb begin
        take    = 1'b0;
        tp_nxt  = 1'b0;
        cnt_nxt = cnt;
        if (state == IDLE) begin
            take = found;
        end else if (held) begin
            if (cnt == CNT_MAX && found) begin
                take   = 1'b1;
                tp_nxt = 1'b1;
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            take = found;
        end
        if (take) cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tp_q <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tp_q <= tp_nxt;
        end
    end

    assign bus.timeout_pulse = tp_q;
`else
    always_comb begin
        take = 1'b0;
        if (state == IDLE || !held) take = found;
    end

    assign bus.timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        idx_nxt   = idx_q;
        ptr_nxt   = ptr;
        if (take) begin
            state_nxt = LOCK;
            grant_nxt = ARB_WIDTH'(1) << win;
            idx_nxt   = win;
            ptr_nxt   = (win == IDX_W'(ARB_WIDTH - 1)) ? '0 : win + IDX_W'(1);
        end else if (state == LOCK && !held) begin
            // Holder released with nobody waiting: go idle, ptr stays put.
            state_nxt = IDLE;
            grant_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            idx_q   <= idx_nxt;
            ptr     <= ptr_nxt;
            valid_q <= (state_nxt == LOCK);
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: reset, rotation, locking, wrap, async reset, optional timeout.
module tb_rr_lock_arbiter;
    localparam int W  = 16;
    localparam int IW = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rr_lock_arbiter_if #(.ARB_WIDTH(W), .IDX_W(IW)) bus ();

    rr_lock_arbiter #(.ARB_WIDTH(W), .IDX_W(IW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [W-1:0] oh;
        oh = W'(1) << idx;
        check({tag, ".grant"}, 64'(bus.grant), 64'(oh));
        check({tag, ".idx"},   64'(bus.grant_idx), 64'(idx));
        check({tag, ".valid"}, 64'(bus.grant_valid), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 64'(bus.grant), 64'd0);
        check({tag, ".valid"}, 64'(bus.grant_valid), 64'd0);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        step();
        check_idle("reset");
        check("reset.idx", 64'(bus.grant_idx), 64'd0);
        check("reset.tp", 64'(bus.timeout_pulse), 64'd0);
        rst = 1'b0;

        // Idle stays idle, then single request / release.
        step();
        check_idle("idle_noreq");
        bus.req = 16'h0001;
        step();
        check_grant("single", 0);
        bus.req = '0;
        step();
        check_idle("single_rel");

        // All requesting; each winner drops for one cycle -> 0..15,0 back to back.
        do_reset();
        bus.req = 16'hFFFF;
        step();
        check_grant("rot0", 0);
        for (int i = 1; i <= 16; i++) begin
            bus.req = 16'hFFFF & ~(16'(1) << ((i - 1) % 16));
            step();
            check_grant($sformatf("rot%0d", i), i % 16);
        end
        bus.req = '0;
        step();
        check_idle("rot_end");

        // Lock on 3 for 10 cycles with 5 and 7 pending.
        do_reset();
        bus.req = 16'h00A8;
        step();
        check_grant("lock_c1", 3);
        for (int i = 2; i <= 10; i++) begin
            step();
            check("lock_hold", 64'(bus.grant), 64'h0008);
        end
        check("lock_tp", 64'(bus.timeout_pulse), 64'd0);
        bus.req = 16'h00A0;
        step();
        check_grant("lock_rel", 5);
        bus.req = '0;
        step();
        check_idle("lock_end");

        // Wrap: 15 granted, ptr wraps to 0, then 14.
        bus.req = 16'h8000;
        step();
        check_grant("wrap15", 15);
        bus.req = 16'h4001;
        step();
        check_grant("wrap0", 0);
        bus.req = 16'h4000;
        step();
        check_grant("wrap14", 14);
        bus.req = '0;
        step();
        check_idle("wrap_end");

        // Async reset between edges clears grant without a clock.
        bus.req = 16'h0008;
        step();
        check_grant("ar_pre", 3);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_idle("ar_async");
        bus.req = '0;
        step();
        rst = 1'b0;
        bus.req = 16'h8001;
        step();
        check_grant("ar_post", 0);
        bus.req = '0;
        step();

        // Dropped in the very cycle it would be sampled -> never granted.
        bus.req = 16'h0010;
        #2;
        bus.req = '0;
        step();
        check_idle("late_drop");

`ifdef ARB_TIMEOUT_EN
        do_reset();
        bus.req = 16'h0204;
        step();
        check_grant("to_c1", 2);
        for (int i = 2; i <= 4; i++) begin
            step();
            check_grant($sformatf("to_c%0d", i), 2);
            check("to_tp_hold", 64'(bus.timeout_pulse), 64'd0);
        end
        step();
        check_grant("to_rot", 9);
        check("to_tp", 64'(bus.timeout_pulse), 64'd1);
        step();
        check_grant("to_after", 9);
        check("to_tp_off", 64'(bus.timeout_pulse), 64'd0);
        do_reset();
        bus.req = 16'h0004;
        for (int i = 0; i < 8; i++) begin
            step();
            check_grant("to_alone", 2);
            check("to_alone_tp", 64'(bus.timeout_pulse), 64'd0);
        end
        bus.req = '0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parametrised round-robin arbiter with registered one-hot grant and grant locking. It is the sequential successor to the combinational fixed-priority arbiter.
- A winner keeps the grant for as long as it holds its request. On release, priority rotates so the requester after the last winner is checked first.
- It sits in front of shared resources: bus masters, memory ports, and FIFO write ports.

Parameters:
ARB_WIDTH, 16, number of requesters (2..64)
IDX_W, $clog2(ARB_WIDTH), width of grant_idx
MAX_HOLD, 32, cycles a grant may be held before forced rotation (only with ARB_TIMEOUT_EN; >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  ARB_WIDTH  request vector, bit i = requester i
grant  output  ARB_WIDTH  registered one-hot grant, all-zero when idle
grant_idx  output  IDX_W  binary index of granted requester, valid when grant_valid=1
grant_valid  output  1  registered, =|grant
timeout_pulse  output  1  one-cycle pulse on forced rotation (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Interface fixed: one clock clk; reset rst is asynchronous and active-high.
- Reset values: grant=0, grant_idx=0, grant_valid=0, timeout_pulse=0, ptr=0, state=IDLE, hold counter=0.
- Internal pointer ptr (IDX_W bits) holds the highest-priority index for the next arbitration. Rotated priority order is ptr, ptr+1, ..., ptr-1, with wrap modulo ARB_WIDTH.
- State IDLE (grant=0):
  - If req!=0, select the first set bit in rotated order.
  - Next cycle: grant is the one-hot of the winner w, grant_idx=w, grant_valid=1, state=LOCK.
  - ptr <= (w+1) mod ARB_WIDTH. When w=ARB_WIDTH-1, ptr wraps to 0.
  - If req==0, stay in IDLE.
- State LOCK (granted index g):
  - If req[g]=1, hold the grant unchanged. Other requests are ignored.
  - If req[g]=0 and other requests are pending, arbitrate in the same cycle using the current ptr. The new grant appears next cycle with no idle bubble and ptr updates. g cannot win because ptr already points past it and req[g]=0.
  - If req[g]=0 and no requests are pending, next cycle grant=0 and state=IDLE. ptr keeps its value.
- Latency: request to grant is 1 cycle. Release to next grant is 1 cycle. grant is never combinationally dependent on req.
- Exactly zero or one grant bit is set in every cycle (one-hot invariant).
- A requester dropping req in the same cycle it would be granted is not granted. Arbitration uses req sampled at the clock edge.
- Simultaneous requests from all requesters with ptr=k: the grant order over successive releases is k, k+1, ..., k-1.
- Reset asserted mid-grant clears grant asynchronously. The first arbitration after reset starts from ptr=0.
- Priority-select logic: a double-width masked priority encoder, or a for-loop over rotated indices. Both are allowed; it must be synthesisable for any ARB_WIDTH up to 64.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each LOCK cycle with req[g]=1.
  - When the counter reaches MAX_HOLD-1 and another requester is pending, the next cycle forcibly grants the next requester in rotated order (ptr updates) and timeout_pulse=1 for one cycle.
  - If no other requester is pending, g keeps the grant and the counter saturates at MAX_HOLD-1.
- Not defined: no counter is instantiated, timeout_pulse is tied to 0, and the grant is held indefinitely.

Test Plan:
- Reset then req=16'h0001 -> one cycle later grant=16'h0001, grant_idx=0, grant_valid=1; drop req -> next cycle grant=0, grant_valid=0.
- req=16'hFFFF held, each granted requester drops its bit one cycle after grant -> grant_idx sequence 0,1,2,...,15,0, back-to-back with no idle cycle.
- Lock: grant on req[3], hold req[3] for 10 cycles while req[5], req[7] are also asserted -> grant stays 16'h0008 for 10 cycles; after the drop, grant=16'h0020 (idx 5).
- Wrap: req[15] granted then released while req[0] and req[14] are pending -> next grant idx 0 (ptr wrapped to 0), then idx 14.
- Async reset asserted mid-LOCK between clock edges -> grant=0 immediately without a clock edge; after reset deasserts, req=16'h8001 -> grant idx 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req[2] held continuously with req[9] pending -> grant on idx 2 for exactly 4 cycles, then idx 9 with timeout_pulse=1 for one cycle; req[2] alone held -> no timeout pulse.
